// File: rtl/test_dkr_if.sv
// ----------------------------------------------------------------------------
// test_dkr_if
//   Operand/result bundle for the 4-bit arithmetic/logic block.
//   master : operand source (drives MR, MS, CI, ALB_MI; observes result/flags)
//   slave  : the ALB itself (consumes operands; drives F_ALB, CO, VO, NO, ZO)
//
//   MR      4  operand A
//   MS      4  operand B
//   CI      1  carry-in
//   ALB_MI  3  operation select
//   F_ALB   4  registered result
//   CO      1  registered carry-out
//   VO      1  registered signed overflow
//   NO      1  registered negative flag
//   ZO      1  registered zero flag
// ----------------------------------------------------------------------------
interface test_dkr_if;
   logic [3:0] MR;
   logic [3:0] MS;
   logic       CI;
   logic [2:0] ALB_MI;
   logic [3:0] F_ALB;
   logic       CO;
   logic       VO;
   logic       NO;
   logic       ZO;

   modport master (
      output MR, MS, CI, ALB_MI,
      input  F_ALB, CO, VO, NO, ZO
   );

   modport slave (
      input  MR, MS, CI, ALB_MI,
      output F_ALB, CO, VO, NO, ZO
   );
endinterface

// File: rtl/test_dkr.sv
// ----------------------------------------------------------------------------
// test_dkr
//   4-bit arithmetic/logic block with registered result and status flags.
//   A new operation is accepted every rising CLK edge; result and flags appear
//   one edge after the operands are sampled. No flag feedback into the next op.
//
//   CLK    in   single clock, rising edge
//   RST_N  in   asynchronous active-low reset, clears result and all flags
//   alb    slave modport of test_dkr_if (operands in, result/flags out)
// ----------------------------------------------------------------------------
module test_dkr (
   input  logic      CLK,
   input  logic      RST_N,
   test_dkr_if.slave alb
);

   typedef enum logic [2:0] {
      OP_SUB  = 3'b000,
      OP_AND  = 3'b001,
      OP_OR   = 3'b010,
      OP_ADD  = 3'b011,
      OP_XOR  = 3'b100,
      OP_PASS = 3'b101,
      OP_NOT  = 3'b110,
      OP_ZERO = 3'b111
   } alb_op_e;

   alb_op_e    op;
   logic [3:0] add_b;
   logic [4:0] sum;

   logic [3:0] f_d, f_q;
   logic       co_d, co_q;
   logic       vo_d, vo_q;
   logic       no_d, no_q;
   logic       zo_d, zo_q;

   assign op = alb_op_e'(alb.ALB_MI);

   // Subtraction reuses the adder with the inverted operand; CI=1 gives a
   // true MR-MS, and CO=1 then reads as "no borrow".
   assign add_b = (op == OP_SUB) ? ~alb.MS : alb.MS;
   assign sum   = {1'b0, alb.MR} + {1'b0, add_b} + {4'b0000, alb.CI};

   always_comb begin
      f_d  = 4'b0000;
      co_d = 1'b0;
      vo_d = 1'b0;
      case (op)
         OP_SUB, OP_ADD: begin
            f_d  = sum[3:0];
            co_d = sum[4];
            // Overflow: operands share a sign and the result sign differs.
            vo_d = (alb.MR[3] == add_b[3]) && (sum[3] != alb.MR[3]);
         end
         OP_AND:  f_d = alb.MR & alb.MS;
         OP_OR:   f_d = alb.MR | alb.MS;
         OP_XOR:  f_d = alb.MR ^ alb.MS;
         OP_PASS: f_d = alb.MR;
         OP_NOT:  f_d = ~alb.MR;
         OP_ZERO: f_d = 4'b0000;
         default: f_d = 4'b0000;
      endcase
      no_d = f_d[3];
      zo_d = (f_d == 4'b0000);
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         f_q  <= 4'b0000;
         co_q <= 1'b0;
         vo_q <= 1'b0;
         no_q <= 1'b0;
         zo_q <= 1'b0;
      end else begin
         f_q  <= f_d;
         co_q <= co_d;
         vo_q <= vo_d;
         no_q <= no_d;
         zo_q <= zo_d;
      end
   end

   assign alb.F_ALB = f_q;
   assign alb.CO    = co_q;
   assign alb.VO    = vo_q;
   assign alb.NO    = no_q;
   assign alb.ZO    = zo_q;

endmodule

// File: tb/tb_test_dkr.sv
module tb_test_dkr;

   logic CLK;
   logic RST_N;

   test_dkr_if alb ();

   test_dkr dut (
      .CLK   (CLK),
      .RST_N (RST_N),
      .alb   (alb.slave)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Expected outputs packed as {F[3:0], CO, VO, NO, ZO}
   typedef struct {
      string      name;
      logic [2:0] op;
      logic [3:0] mr;
      logic [3:0] ms;
      logic       ci;
      logic [7:0] exp;
   } vec_t;

   typedef struct {
      string      name;
      logic [7:0] exp;
   } sb_t;

   sb_t  exp_q[$];
   int   n_checks;
   int   n_fail;

   function automatic logic [7:0] outs();
      return {alb.F_ALB, alb.CO, alb.VO, alb.NO, alb.ZO};
   endfunction

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got F/CO/VO/NO/ZO=%b_%b required %b_%b",
                  name, act[7:4], act[3:0], exp[7:4], exp[3:0]);
      end
   endtask

   // Reference model using signed-range overflow rather than sign-bit logic.
   function automatic logic [7:0] model(input logic [2:0] op, input logic [3:0] mr,
                                        input logic [3:0] ms, input logic ci);
      int         b, s, ss;
      logic [3:0] f;
      logic       co, vo;
      co = 1'b0;
      vo = 1'b0;
      case (op)
         3'b000, 3'b011: begin
            b  = (op == 3'b000) ? (15 - int'(ms)) : int'(ms);
            s  = int'(mr) + b + int'(ci);
            f  = s[3:0];
            co = (s >= 16);
            ss = (int'(mr) >= 8 ? int'(mr) - 16 : int'(mr)) +
                 (b >= 8 ? b - 16 : b) + int'(ci);
            vo = (ss > 7) || (ss < -8);
         end
         3'b001: f = mr & ms;
         3'b010: f = mr | ms;
         3'b100: f = mr ^ ms;
         3'b101: f = mr;
         3'b110: f = ~mr;
         default: f = 4'b0000;
      endcase
      return {f, co, vo, f[3], (f == 4'b0000)};
   endfunction

   // Scoreboard monitor: every pushed expectation is due one edge after drive.
   always @(posedge CLK) begin
      sb_t e;
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check(e.name, outs(), e.exp);
      end
   end

   task automatic drive(input string name, input logic [2:0] op, input logic [3:0] mr,
                        input logic [3:0] ms, input logic ci, input logic push,
                        input logic [7:0] exp);
      sb_t e;
      @(negedge CLK);
      alb.ALB_MI = op;
      alb.MR     = mr;
      alb.MS     = ms;
      alb.CI     = ci;
      if (push) begin
         e.name = name;
         e.exp  = exp;
         exp_q.push_back(e);
      end
   endtask

   vec_t vecs[14];

   initial begin
      n_checks   = 0;
      n_fail     = 0;
      RST_N      = 1'b0;
      alb.MR     = 4'h0;
      alb.MS     = 4'h0;
      alb.CI     = 1'b0;
      alb.ALB_MI = 3'b000;

      vecs[0]  = '{"add_6_3_1",   3'b011, 4'b0110, 4'b0011, 1'b1, 8'b1010_0110};
      vecs[1]  = '{"add_f_1_1",   3'b011, 4'b1111, 4'b0001, 1'b1, 8'b0001_1000};
      vecs[2]  = '{"sub_6_3_1",   3'b000, 4'b0110, 4'b0011, 1'b1, 8'b0011_1000};
      vecs[3]  = '{"sub_3_6_0",   3'b000, 4'b0011, 4'b0110, 1'b0, 8'b1100_0010};
      vecs[4]  = '{"sub_5_5_1",   3'b000, 4'b0101, 4'b0101, 1'b1, 8'b0000_1001};
      vecs[5]  = '{"and",         3'b001, 4'b0110, 4'b0011, 1'b1, 8'b0010_0000};
      vecs[6]  = '{"or",          3'b010, 4'b0110, 4'b0011, 1'b1, 8'b0111_0000};
      vecs[7]  = '{"xor",         3'b100, 4'b0110, 4'b0011, 1'b1, 8'b0101_0000};
      vecs[8]  = '{"pass",        3'b101, 4'b0110, 4'b0011, 1'b1, 8'b0110_0000};
      vecs[9]  = '{"not",         3'b110, 4'b0110, 4'b0011, 1'b1, 8'b1001_0010};
      vecs[10] = '{"zero",        3'b111, 4'b0110, 4'b0011, 1'b1, 8'b0000_0001};
      vecs[11] = '{"add_7_1_0",   3'b011, 4'b0111, 4'b0001, 1'b0, 8'b1000_0110};
      vecs[12] = '{"sub_8_1_1",   3'b000, 4'b1000, 4'b0001, 1'b1, 8'b0111_1100};
      vecs[13] = '{"add_8_8_0",   3'b011, 4'b1000, 4'b1000, 1'b0, 8'b0000_1101};

      // Reset state
      repeat (2) @(posedge CLK);
      #1 check("reset_state", outs(), 8'h00);
      @(negedge CLK);
      RST_N = 1'b1;

      // Directed table, back-to-back with a new opcode every cycle
      foreach (vecs[i])
         drive(vecs[i].name, vecs[i].op, vecs[i].mr, vecs[i].ms, vecs[i].ci, 1'b1, vecs[i].exp);

      // Randomised back-to-back stream against the model
      for (int i = 0; i < 40; i++) begin
         logic [2:0] op;
         logic [3:0] mr, ms;
         logic       ci;
         op = 3'($urandom_range(0, 7));
         mr = 4'($urandom_range(0, 15));
         ms = 4'($urandom_range(0, 15));
         ci = 1'($urandom_range(0, 1));
         drive($sformatf("rand_%0d_op%0d", i, op), op, mr, ms, ci, 1'b1, model(op, mr, ms, ci));
      end

      // Asynchronous reset mid-run: load a non-zero result, then pull reset
      // between edges and expect an immediate clear.
      drive("pre_reset", 3'b110, 4'b0000, 4'b0000, 1'b0, 1'b1, 8'b1111_0010);
      @(posedge CLK);
      #3;
      RST_N = 1'b0;
      #1 check("async_reset_clear", outs(), 8'h00);

      // Held in reset: a clock edge with live inputs must not load anything
      drive("in_reset", 3'b011, 4'b0110, 4'b0011, 1'b1, 1'b0, 8'h00);
      @(posedge CLK);
      #1 check("held_in_reset", outs(), 8'h00);

      // Deassert between edges: the first edge captures the present inputs
      @(negedge CLK);
      alb.ALB_MI = 3'b011;
      alb.MR     = 4'b1111;
      alb.MS     = 4'b0001;
      alb.CI     = 1'b1;
      RST_N      = 1'b1;
      exp_q.push_back('{"first_after_reset", 8'b0001_1000});
      drive("after_reset_2", 3'b000, 4'b0101, 4'b0101, 1'b1, 1'b1, 8'b0000_1001);

      // Bounded drain of the scoreboard
      for (int i = 0; i < 4 && exp_q.size() > 0; i++)
         @(posedge CLK);
      #2;
      if (exp_q.size() != 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL scoreboard_drain: %0d results outstanding, required 0", exp_q.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
